// File: rtl/ravenoc_route_pkg.sv
// Shared types and helpers for the per-VC input router: flit types, port
// indices, routing algorithm selector and the index-to-one-hot mapping.
package ravenoc_route_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    XY = 1'b0,
    YX = 1'b1
  } routing_alg_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } vc_state_e;

  localparam logic [2:0] NORTH = 3'd0;
  localparam logic [2:0] SOUTH = 3'd1;
  localparam logic [2:0] WEST  = 3'd2;
  localparam logic [2:0] EAST  = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  function automatic logic [4:0] idx_to_onehot(input logic [2:0] idx);
    logic [4:0] oh;
    oh = '0;
    case (idx)
      NORTH:   oh = 5'b00001;
      SOUTH:   oh = 5'b00010;
      WEST:    oh = 5'b00100;
      EAST:    oh = 5'b01000;
      LOCAL:   oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/input_router_vc_if.sv
// Flit-in / route-out handshake bundle of the per-VC input router.
interface input_router_vc_if #(
  parameter int FLIT_W = 34,
  parameter int N_VC   = 4,
  parameter int VC_W   = 2
);
  logic              flit_valid_i;
  logic              flit_ready_o;
  logic [FLIT_W-1:0] flit_i;
  logic [VC_W-1:0]   vc_id_i;
  logic              route_valid_o;
  logic              route_ready_i;
  logic [4:0]        route_port_o;
  logic [VC_W-1:0]   route_vc_o;
  logic [FLIT_W-1:0] flit_o;
  logic              err_o;
  logic [N_VC-1:0]   vc_locked_o;

  modport slave (
    input  flit_valid_i, flit_i, vc_id_i, route_ready_i,
    output flit_ready_o, route_valid_o, route_port_o, route_vc_o, flit_o, err_o, vc_locked_o
  );

  modport master (
    output flit_valid_i, flit_i, vc_id_i, route_ready_i,
    input  flit_ready_o, route_valid_o, route_port_o, route_vc_o, flit_o, err_o, vc_locked_o
  );
endinterface

// File: rtl/route_calc.sv
// Combinational dimension-order route: destination vs. local coordinates to a
// 3-bit output port index, X-first (XY) or Y-first (YX).
module route_calc
  import ravenoc_route_pkg::*;
#(
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int ROUTING_ALG = 0
) (
  input  logic [X_W-1:0] i_dx,
  input  logic [Y_W-1:0] i_dy,
  input  logic [X_W-1:0] i_rx,
  input  logic [Y_W-1:0] i_ry,
  output logic [2:0]     o_port_idx
);

  logic       w_x_eq;
  logic       w_y_eq;
  logic [2:0] w_x_idx;
  logic [2:0] w_y_idx;

  assign w_x_eq  = (i_dx == i_rx);
  assign w_y_eq  = (i_dy == i_ry);
  assign w_x_idx = (i_dx > i_rx) ? EAST : WEST;
  assign w_y_idx = (i_dy > i_ry) ? NORTH : SOUTH;

  generate
    if (ROUTING_ALG == int'(YX)) begin : g_yx
      assign o_port_idx = !w_y_eq ? w_y_idx : (!w_x_eq ? w_x_idx : LOCAL);
    end else begin : g_xy
      assign o_port_idx = !w_x_eq ? w_x_idx : (!w_y_eq ? w_y_idx : LOCAL);
    end
  endgenerate

endmodule

// File: rtl/input_router_vc.sv
// Per-VC input router: locks a dimension-order route on a head flit, reuses it
// for body/tail flits, flags protocol errors, single registered output stage.
module input_router_vc
  import ravenoc_route_pkg::*;
#(
  parameter int FLIT_W      = 34,
  parameter int X_W         = 2,
  parameter int Y_W         = 2,
  parameter int N_VC        = 4,
  parameter int VC_W        = 2,
  parameter int ROUTING_ALG = 0
) (
  input logic                 clk,
  input logic                 arst,
  input logic [X_W-1:0]       router_x_i,
  input logic [Y_W-1:0]       router_y_i,
  input_router_vc_if.slave    bus
);

  localparam int N_VC_PAD = 2 ** VC_W;

  flit_type_e       w_type;
  logic [X_W-1:0]   w_dx;
  logic [Y_W-1:0]   w_dy;
  logic [2:0]       w_calc_idx;
  logic             w_ready;
  logic             w_accept;
  logic             w_vc_ok;
  logic [N_VC_PAD-1:0] w_vc_exists;

  vc_state_e        r_state     [N_VC];
  logic [2:0]       r_port_idx  [N_VC];
  vc_state_e        w_state_next[N_VC];
  logic [2:0]       w_port_next [N_VC];

  vc_state_e        w_cur_state;
  logic [2:0]       w_cur_port;
  logic             w_upd_en;
  vc_state_e        w_upd_state;
  logic [2:0]       w_upd_port;
  logic             w_emit;
  logic [2:0]       w_emit_idx;
  logic             w_err;

  logic              r_route_valid;
  logic [4:0]        r_route_port;
  logic [VC_W-1:0]   r_route_vc;
  logic [FLIT_W-1:0] r_flit;
  logic              r_err;

  assign w_type   = flit_type_e'(bus.flit_i[FLIT_W-1 -: 2]);
  assign w_dx     = bus.flit_i[FLIT_W-3 -: X_W];
  assign w_dy     = bus.flit_i[FLIT_W-3-X_W -: Y_W];
  assign w_ready  = !r_route_valid || bus.route_ready_i;
  assign w_accept = bus.flit_valid_i && w_ready;

  route_calc #(
    .X_W         (X_W),
    .Y_W         (Y_W),
    .ROUTING_ALG (ROUTING_ALG)
  ) u_route_calc (
    .i_dx       (w_dx),
    .i_dy       (w_dy),
    .i_rx       (router_x_i),
    .i_ry       (router_y_i),
    .o_port_idx (w_calc_idx)
  );

  // Encodings of vc_id_i beyond N_VC-1 are illegal and get dropped as errors.
  genvar gi;
  generate
    for (gi = 0; gi < N_VC_PAD; gi++) begin : g_vc_exists
      assign w_vc_exists[gi] = (gi < N_VC);
    end
    for (gi = 0; gi < N_VC; gi++) begin : g_locked
      assign bus.vc_locked_o[gi] = (r_state[gi] == LOCKED);
    end
  endgenerate

  assign w_vc_ok = w_vc_exists[bus.vc_id_i];

  always_comb begin
    w_cur_state = IDLE;
    w_cur_port  = '0;
    for (int i = 0; i < N_VC; i++) begin
      if (bus.vc_id_i == VC_W'(i)) begin
        w_cur_state = r_state[i];
        w_cur_port  = r_port_idx[i];
      end
    end
  end

  always_comb begin
    w_emit      = 1'b0;
    w_emit_idx  = w_calc_idx;
    w_err       = 1'b0;
    w_upd_en    = 1'b0;
    w_upd_state = w_cur_state;
    w_upd_port  = w_cur_port;
    if (w_accept) begin
      if (!w_vc_ok) begin
        w_err = 1'b1;
      end else if (w_type == HEAD || w_type == HEAD_TAIL) begin
        // A header on a locked VC is flagged but still honoured as a fresh packet.
        w_err    = (w_cur_state == LOCKED);
        w_emit   = 1'b1;
        w_upd_en = 1'b1;
        if (w_type == HEAD) begin
          w_upd_state = LOCKED;
          w_upd_port  = w_calc_idx;
        end else begin
          w_upd_state = IDLE;
        end
      end else if (w_cur_state == LOCKED) begin
        w_emit     = 1'b1;
        w_emit_idx = w_cur_port;
        if (w_type == TAIL) begin
          w_upd_en    = 1'b1;
          w_upd_state = IDLE;
        end
      end else begin
        w_err = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_VC; i++) begin
      w_state_next[i] = r_state[i];
      w_port_next[i]  = r_port_idx[i];
      if (w_upd_en && bus.vc_id_i == VC_W'(i)) begin
        w_state_next[i] = w_upd_state;
        w_port_next[i]  = w_upd_port;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < N_VC; i++) begin
        r_state[i]    <= IDLE;
        r_port_idx[i] <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_port_idx <= w_port_next;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_route_valid <= 1'b0;
      r_route_port  <= '0;
      r_route_vc    <= '0;
      r_flit        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_ready) begin
        r_route_valid <= w_emit;
        if (w_emit) begin
          r_route_port <= idx_to_onehot(w_emit_idx);
          r_route_vc   <= bus.vc_id_i;
          r_flit       <= bus.flit_i;
        end
      end
    end
  end

  assign bus.flit_ready_o  = w_ready;
  assign bus.route_valid_o = r_route_valid;
  assign bus.route_port_o  = r_route_port;
  assign bus.route_vc_o    = r_route_vc;
  assign bus.flit_o        = r_flit;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_input_router_vc.sv
// Scoreboard bench: an XY and a YX instance see identical stimulus; a packet-level
// reference model predicts routes, errors and lock status for both.
module tb_input_router_vc;
  import ravenoc_route_pkg::*;

  localparam int FLIT_W = 34;
  localparam int X_W    = 2;
  localparam int Y_W    = 2;
  localparam int N_VC   = 4;
  localparam int VC_W   = 2;
  localparam int PAY_W  = FLIT_W - 2 - X_W - Y_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst = 1'b1;
  logic [X_W-1:0]    rx = '0;
  logic [Y_W-1:0]    ry = '0;
  logic              flit_valid = 1'b0;
  logic [FLIT_W-1:0] flit = '0;
  logic [VC_W-1:0]   vc_id = '0;
  logic              route_ready = 1'b1;
  bit                rdy_force = 1'b1;
  bit                rdy_val = 1'b1;
  bit                mon_en = 1'b0;

  input_router_vc_if #(.FLIT_W(FLIT_W), .N_VC(N_VC), .VC_W(VC_W)) bus_xy ();
  input_router_vc_if #(.FLIT_W(FLIT_W), .N_VC(N_VC), .VC_W(VC_W)) bus_yx ();

  assign bus_xy.flit_valid_i  = flit_valid;
  assign bus_xy.flit_i        = flit;
  assign bus_xy.vc_id_i       = vc_id;
  assign bus_xy.route_ready_i = route_ready;
  assign bus_yx.flit_valid_i  = flit_valid;
  assign bus_yx.flit_i        = flit;
  assign bus_yx.vc_id_i       = vc_id;
  assign bus_yx.route_ready_i = route_ready;

  input_router_vc #(.FLIT_W(FLIT_W), .X_W(X_W), .Y_W(Y_W), .N_VC(N_VC), .VC_W(VC_W), .ROUTING_ALG(0)) dut_xy (
    .clk(clk), .arst(arst), .router_x_i(rx), .router_y_i(ry), .bus(bus_xy));
  input_router_vc #(.FLIT_W(FLIT_W), .X_W(X_W), .Y_W(Y_W), .N_VC(N_VC), .VC_W(VC_W), .ROUTING_ALG(1)) dut_yx (
    .clk(clk), .arst(arst), .router_x_i(rx), .router_y_i(ry), .bus(bus_yx));

  typedef struct {
    logic [4:0]        pxy;
    logic [4:0]        pyx;
    logic [VC_W-1:0]   vc;
    logic [FLIT_W-1:0] f;
  } exp_t;

  exp_t       log_q[$];
  int         rd[2];
  int         err_seen[2];
  int         err_exp;
  bit         m_locked[N_VC];
  logic [4:0] m_pxy[N_VC];
  logic [4:0] m_pyx[N_VC];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Dimension-order routing from signed coordinate differences.
  function automatic logic [4:0] ref_route(input int dx, input int dy, input int x, input int y, input bit yx);
    int ex = dx - x;
    int ey = dy - y;
    logic [4:0] xp = (ex > 0) ? 5'b01000 : 5'b00100;
    logic [4:0] yp = (ey > 0) ? 5'b00001 : 5'b00010;
    if (ex == 0 && ey == 0) return 5'b10000;
    if (yx) return (ey != 0) ? yp : xp;
    return (ex != 0) ? xp : yp;
  endfunction

  function automatic logic [N_VC-1:0] model_locked();
    logic [N_VC-1:0] v = '0;
    for (int i = 0; i < N_VC; i++) v[i] = m_locked[i];
    return v;
  endfunction

  task automatic model_reset();
    log_q.delete();
    rd[0] = 0; rd[1] = 0; err_seen[0] = 0; err_seen[1] = 0; err_exp = 0;
    for (int i = 0; i < N_VC; i++) begin
      m_locked[i] = 1'b0; m_pxy[i] = '0; m_pyx[i] = '0;
    end
  endtask

  task automatic model_accept(input logic [1:0] ft, input logic [FLIT_W-1:0] f, input int vc);
    int dx = int'(f[FLIT_W-3 -: X_W]);
    int dy = int'(f[FLIT_W-3-X_W -: Y_W]);
    exp_t e;
    if (ft == 2'b00 || ft == 2'b11) begin
      if (m_locked[vc]) err_exp++;
      e.pxy = ref_route(dx, dy, int'(rx), int'(ry), 1'b0);
      e.pyx = ref_route(dx, dy, int'(rx), int'(ry), 1'b1);
      e.vc = VC_W'(vc); e.f = f;
      log_q.push_back(e);
      m_locked[vc] = (ft == 2'b00);
      if (ft == 2'b00) begin m_pxy[vc] = e.pxy; m_pyx[vc] = e.pyx; end
    end else if (!m_locked[vc]) begin
      err_exp++;
    end else begin
      e.pxy = m_pxy[vc]; e.pyx = m_pyx[vc]; e.vc = VC_W'(vc); e.f = f;
      log_q.push_back(e);
      if (ft == 2'b10) m_locked[vc] = 1'b0;
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic send(input logic [1:0] ft, input int dx, input int dy, input int vc, output int waited);
    logic [FLIT_W-1:0] f;
    bit ok = 1'b1;
    f = {ft, X_W'(dx), Y_W'(dy), PAY_W'($urandom)};
    flit = f; vc_id = VC_W'(vc); flit_valid = 1'b1; waited = 0;
    forever begin
      @(negedge clk);
      if (bus_xy.flit_ready_o) break;
      waited++;
      if (waited > 100) begin
        check("accept_timeout", 64'(waited), 64'(100)); ok = 1'b0; break;
      end
    end
    @(posedge clk);
    if (ok) model_accept(ft, f, vc);
    #1 flit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2 route_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  task automatic mon(input int d, input logic v, input logic [4:0] port, input logic [VC_W-1:0] rvc,
                     input logic [FLIT_W-1:0] f, input logic err, input logic [N_VC-1:0] lk, input logic frdy);
    exp_t e;
    check($sformatf("ready_rule%0d", d), frdy, !v || route_ready);
    check($sformatf("vc_locked%0d", d), lk, model_locked());
    if (v && route_ready) begin
      check($sformatf("route_pending%0d", d), rd[d] < log_q.size(), 1'b1);
      if (rd[d] < log_q.size()) begin
        e = log_q[rd[d]];
        rd[d]++;
        check($sformatf("port%0d", d), port, d ? e.pyx : e.pxy);
        check($sformatf("vc%0d", d), rvc, e.vc);
        check($sformatf("flit%0d", d), f, e.f);
        $display("route dut%0d vc=%0d port=%b", d, rvc, port);
      end
    end
    if (err) begin
      check($sformatf("err_pending%0d", d), err_seen[d] < err_exp, 1'b1);
      err_seen[d]++;
      $display("err dut%0d", d);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus_xy.route_valid_o, bus_xy.route_port_o, bus_xy.route_vc_o, bus_xy.flit_o,
          bus_xy.err_o, bus_xy.vc_locked_o, bus_xy.flit_ready_o);
      mon(1, bus_yx.route_valid_o, bus_yx.route_port_o, bus_yx.route_vc_o, bus_yx.flit_o,
          bus_yx.err_o, bus_yx.vc_locked_o, bus_yx.flit_ready_o);
    end
  end

  task automatic drain_check(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_routes%0d", tag, d), 64'(rd[d]), 64'(log_q.size()));
      check($sformatf("%s_errs%0d", tag, d), 64'(err_seen[d]), 64'(err_exp));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    model_reset();
    #3 arst = 1'b0;
    #1;
    check("rst_valid", bus_xy.route_valid_o, 1'b0);
    check("rst_port", bus_xy.route_port_o, 5'b0);
    check("rst_vc", bus_xy.route_vc_o, 2'b0);
    check("rst_flit", bus_xy.flit_o, '0);
    check("rst_err", bus_xy.err_o, 1'b0);
    check("rst_locked", bus_xy.vc_locked_o, 4'b0);
    check("rst_ready", bus_xy.flit_ready_o, 1'b1);
    repeat (2) @(posedge clk);
    #1 arst = 1'b1;
    rx = 2'd1; ry = 2'd1;
    idle(1);
    mon_en = 1'b1;

    // Locked packet East (XY) / South (YX).
    send(2'b00, 3, 0, 0, w);
    send(2'b01, 0, 0, 0, w);
    send(2'b10, 0, 0, 0, w);
    // Single-flit packets, including one to the local port.
    send(2'b11, 3, 0, 0, w);
    send(2'b11, 1, 1, 0, w);
    // Interleaved packets on VC0 (West) and VC1 (North).
    send(2'b00, 0, 1, 0, w);
    send(2'b00, 1, 3, 1, w);
    send(2'b01, 0, 0, 1, w);
    send(2'b10, 0, 0, 0, w);
    send(2'b10, 0, 0, 1, w);
    idle(3);
    drain_check("directed");

    // Backpressure: route held for three cycles, then next flit taken at once.
    send(2'b00, 2, 3, 1, w);
    rdy_val = 1'b0;
    flit = {2'b01, 2'b00, 2'b00, PAY_W'($urandom)}; vc_id = 2'd1; flit_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready", bus_xy.flit_ready_o, 1'b0);
      check("bp_valid", bus_xy.route_valid_o, 1'b1);
      check("bp_port", bus_xy.route_port_o, log_q[rd[0]].pxy);
      check("bp_flit", bus_xy.flit_o, log_q[rd[0]].f);
      check("bp_port_yx", bus_yx.route_port_o, log_q[rd[1]].pyx);
      @(posedge clk); #1;
    end
    rdy_val = 1'b1;
    send(2'b01, 0, 0, 1, w);
    check("bp_same_cycle", 64'(w), 64'(0));
    send(2'b10, 0, 0, 1, w);

    // Body on an idle VC, then a header on a locked VC.
    send(2'b01, 0, 0, 2, w);
    send(2'b00, 3, 3, 0, w);
    send(2'b00, 0, 0, 0, w);
    send(2'b10, 0, 0, 0, w);
    idle(3);
    drain_check("errors");

    // Asynchronous reset while a route is stalled on a locked VC.
    send(2'b00, 3, 0, 0, w);
    rdy_val = 1'b0;
    #3 mon_en = 1'b0;
    arst = 1'b0;
    #1;
    check("mid_rst_valid", bus_xy.route_valid_o, 1'b0);
    check("mid_rst_port", bus_xy.route_port_o, 5'b0);
    check("mid_rst_flit", bus_xy.flit_o, '0);
    check("mid_rst_locked", bus_xy.vc_locked_o, 4'b0);
    check("mid_rst_ready", bus_xy.flit_ready_o, 1'b1);
    model_reset();
    @(posedge clk); #1 arst = 1'b1;
    rdy_val = 1'b1;
    idle(1);
    mon_en = 1'b1;
    send(2'b01, 0, 0, 0, w);
    idle(3);
    drain_check("after_rst");

    // Randomised traffic, mostly well-formed packets, random backpressure.
    rdy_force = 1'b0;
    for (int it = 0; it < 400; it++) begin
      int v;
      logic [1:0] ft;
      if (it % 100 == 0) begin rx = X_W'($urandom); ry = Y_W'($urandom); end
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 2));
      end else begin
        v = $urandom_range(0, N_VC - 1);
        if ($urandom_range(0, 7) == 0) ft = 2'($urandom);
        else if (m_locked[v]) ft = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b01;
        else ft = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
        send(ft, $urandom_range(0, 3), $urandom_range(0, 3), v, w);
      end
    end
    rdy_force = 1'b1; rdy_val = 1'b1;
    idle(6);
    drain_check("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_router_vc.md
Name: input_router_vc

Overview:
- Parametrised successor of the single-table input router.
- Sits at each router input port, between the input buffer and the switch allocator.
- For each virtual channel it computes the output port from a head flit using XY or YX dimension-order routing, and locks that route for the whole packet.
- Releases the route on the tail, flags protocol violations, and presents one registered route per accepted flit over a valid/ready handshake.

Parameters:
- FLIT_W, 34, total flit width; [FLIT_W-1:FLIT_W-2] is the flit type.
- X_W, 2, width of the X coordinate field.
- Y_W, 2, width of the Y coordinate field.
- N_VC, 4, number of virtual channels (>=1).
- VC_W, 2, vc id width, equal to max(1, clog2(N_VC)).
- ROUTING_ALG, 0, 0 = XY (X resolved first), 1 = YX (Y resolved first).

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-low (asserted at 0).
- router_x_i  in  X_W  this router's X coordinate; quasi-static.
- router_y_i  in  Y_W  this router's Y coordinate; quasi-static.
- flit_valid_i  in  1  input flit valid.
- flit_ready_o  out  1  input flit accepted when valid and ready are both 1.
- flit_i  in  FLIT_W  flit; dest X at [FLIT_W-3 -: X_W], dest Y directly below it.
- vc_id_i  in  VC_W  VC of the flit.
- route_valid_o  out  1  registered route valid.
- route_ready_i  in  1  downstream accepts the route.
- route_port_o  out  5  one-hot port: [0]=North, [1]=South, [2]=West, [3]=East, [4]=Local.
- route_vc_o  out  VC_W  VC of the routed flit.
- flit_o  out  FLIT_W  flit passed through, aligned with route_port_o.
- err_o  out  1  one-cycle pulse on a protocol error.
- vc_locked_o  out  N_VC  per-VC locked status.

Behaviour:
- Flit types: 00 = head, 01 = body, 10 = tail, 11 = head-tail (single-flit packet).
- flit_ready_o = !route_valid_o || route_ready_i (combinational). This is a single pipeline stage with a latency of 1 cycle.
- While route_valid_o && !route_ready_i, all outputs hold stable.
- Accepted flit with no error:
  - route_valid_o=1 on the next cycle, with route_port_o, route_vc_o and flit_o loaded.
  - If nothing is accepted and the downstream consumes the route, route_valid_o drops to 0.
- Route calculation (XY), using dest (dx, dy) and local (rx, ry), unsigned compare:
  - dx>rx -> East; dx<rx -> West.
  - Otherwise dy>ry -> North; dy<ry -> South.
  - Otherwise Local.
  - YX applies the same rules with Y resolved before X.
- Per-VC state machine: IDLE / LOCKED, plus a 3-bit port-index table entry.
- IDLE, head: compute the route, emit it, store it, go to LOCKED.
- IDLE, head-tail: compute and emit the route; stay IDLE; the table is not written.
- IDLE, body or tail: error.
  - The flit is consumed and dropped; no route is emitted.
  - err_o pulses 1 on the next cycle; the state is unchanged.
- LOCKED, body: emit the stored route.
- LOCKED, tail: emit the stored route and go to IDLE.
- LOCKED, head or head-tail:
  - err_o pulses 1, then the new header is treated as if the VC were IDLE: the table is overwritten and it re-locks (head) or goes to IDLE (head-tail).
  - The route is emitted.
- Per-VC state is independent: interleaved flits of different VCs never disturb each other's table.
- vc_id_i >= N_VC: treated as an error; the flit is dropped and err_o pulses.
- The routing table is written only on an accepted flit. Router coordinates are sampled at acceptance.
- Reset (arst=0, asynchronous):
  - route_valid_o=0, route_port_o=0, route_vc_o=0, flit_o=0, err_o=0.
  - All VCs IDLE, vc_locked_o=0, table cleared.
  - flit_ready_o=1 once route_valid_o is 0.
- Reset mid-packet: the lock is lost; subsequent body/tail flits of that packet are errors.
- Deassertion of arst is synchronised externally; the block needs no internal synchroniser.

Decomposition:
- Package ravenoc_route_pkg holds:
  - the flit_type enum (HEAD, BODY, TAIL, HEAD_TAIL);
  - port index localparams (NORTH=0 .. LOCAL=4);
  - an idx-to-one-hot function;
  - the routing-algorithm enum (XY, YX).
- Sub-module route_calc: purely combinational. It takes (dx, dy, rx, ry, ROUTING_ALG) and returns a 3-bit port index; it is instantiated once.
- The per-VC state/table registers and the output stage live in input_router_vc.

Test Plan:
- XY, router (1,1), VC0: head dest (3,0), body, tail -> three routes with route_port_o=5'b01000 (East); vc_locked_o[0] goes 1 after the head and 0 after the tail; err_o=0.
- YX, router (1,1): head-tail dest (3,0) -> route_port_o=5'b00010 (South); head-tail dest (1,1) -> 5'b10000 (Local); VC stays IDLE.
- VC0 head dest West, VC1 head dest North, then interleaved VC1 body, VC0 tail, VC1 tail -> ports 00100, 00001, 00001, 00100, 00001, with the correct route_vc_o on each.
- Backpressure: route_ready_i=0 for 3 cycles after a head -> flit_ready_o=0, all outputs stable; on release the next flit is accepted in the same cycle.
- Body on IDLE VC2 -> no route_valid_o, err_o=1 for exactly one cycle, vc_locked_o unchanged; head on LOCKED VC0 -> err_o=1 and the route is recomputed.
- arst=0 asserted while VC0 is LOCKED with route_valid_o=1 -> all outputs 0 immediately; after release, a body on VC0 raises err_o.
